// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, blank code
// and the active-low hex-to-segment table ({g,f,e,d,c,b,a}).
package sseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // NOTE: a constant table is ROM, not state; it folds into logic and needs no reset.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/scan_tick_gen.sv
// Dwell prescaler for the scan driver: counts 0..CLK_DIV-1 and pulses tick
// for one cycle on the terminal count. CLK_DIV=1 ticks every cycle.
module scan_tick_gen #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver displaying shadowed value/dp data.
// Optional leading-zero blanking of digits 3..1 when SSEG_BLANK_EN is defined.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    logic                    tick;
    logic [IDX_W-1:0]        idx_q,   idx_d;
    logic [4*NUM_DIGITS-1:0] val_q,   val_d;
    logic [NUM_DIGITS-1:0]   dpm_q,   dpm_d;
    logic [6:0]              seg_q,   seg_d;
    logic                    dp_q,    dp_d;
    logic [NUM_DIGITS-1:0]   an_q,    an_d;
    logic [3:0]              nibble;

    scan_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        idx_d  = tick ? idx_q + IDX_W'(1) : idx_q;
        val_d  = load ? value : val_q;
        dpm_d  = load ? dp_in : dpm_q;

        // Display path reads only the shadow registers, never the live inputs.
        nibble = val_q[{idx_q, 2'b00} +: 4];
        an_d   = '1;
        an_d[idx_q] = 1'b0;
        dp_d   = ~dpm_q[idx_q];
        seg_d  = SEG_TABLE[nibble];
`ifdef SSEG_BLANK_EN
        if ((idx_q != '0) && ((val_q >> {idx_q, 2'b00}) == '0)) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            val_q <= '0;
            dpm_q <= '0;
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            idx_q <= idx_d;
            val_q <= val_d;
            dpm_q <= dpm_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench: two drivers (CLK_DIV=4 and CLK_DIV=1) share stimulus; expected
// outputs are pushed per driven cycle and compared against outputs captured each negedge.
module tb_sseg_scan_driver;

    typedef struct packed {
        logic [3:0] an4;
        logic [6:0] seg4;
        logic       dp4;
        logic [3:0] an1;
        logic [6:0] seg1;
        logic       dp1;
    } obs_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [15:0] value  = '0;
    logic [3:0]  dp_in  = '0;
    logic        load   = 1'b0;
    logic [6:0]  seg4, seg1;
    logic        dp4, dp1;
    logic [3:0]  an4, an1;

    int          tests_run    = 0;
    int          tests_failed = 0;

    // Reference model state: edges since reset release and the shadow contents.
    int          edge_cnt = 0;
    logic [15:0] m_val    = '0;
    logic [3:0]  m_dp     = '0;

    obs_t        exp_q[$];
    obs_t        obs_q[$];

    always #5 clk = ~clk;

    sseg_scan_driver #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .seg(seg4), .dp(dp4), .an(an4)
    );

    sseg_scan_driver #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .seg(seg1), .dp(dp1), .an(an1)
    );

    always @(negedge clk) obs_q.push_back(obs_t'({an4, seg4, dp4, an1, seg1, dp1}));

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Output after edge n (n>=1 since release) shows digit ((n-1)/div) mod 4.
    function automatic logic [11:0] model_out(input int div, input int n);
        int         d;
        logic [3:0] a;
        logic [6:0] s;
        d    = ((n - 1) / div) % 4;
        a    = 4'b1111;
        a[d] = 1'b0;
        s    = ref_seg(m_val[4*d +: 4]);
`ifdef SSEG_BLANK_EN
        if (d > 0 && (m_val >> (4*d)) == 16'h0000) s = 7'h7F;
`endif
        return {a, s, ~m_dp[d]};
    endfunction

    task automatic cycle(input logic rst, input logic ld, input logic [15:0] v, input logic [3:0] d);
        reset = rst;
        load  = ld;
        value = v;
        dp_in = d;
        if (rst) begin
            exp_q.push_back(obs_t'({4'b1111, 7'h7F, 1'b1, 4'b1111, 7'h7F, 1'b1}));
            edge_cnt = 0;
            m_val    = '0;
            m_dp     = '0;
        end else begin
            exp_q.push_back(obs_t'({model_out(4, edge_cnt + 1), model_out(1, edge_cnt + 1)}));
            edge_cnt++;
            if (ld) begin
                m_val = v;
                m_dp  = d;
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'hFFFF, 4'hF);
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'h9999, 4'hF);
        idle(2);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL reset[%0d]: no output captured, required %h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL reset[%0d]: got %h required %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_scan();
        obs_t e, o;
        cycle(1'b0, 1'b1, 16'h1234, 4'h0);
        idle(32);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scan[%0d]: no output captured, required %h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL scan[%0d]: got %h required %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_load_on_tick();
        obs_t e, o;
        while ((edge_cnt + 1) % 4 != 0) idle(1);
        cycle(1'b0, 1'b1, 16'hABCD, 4'b0101);
        idle(20);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL load_on_tick[%0d]: no output captured, required %h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL load_on_tick[%0d]: got %h required %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1, 16'hABCD, 4'b0101);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: no output captured, required %h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL back_to_back[%0d]: got %h required %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_blank();
        obs_t e, o;
        cycle(1'b0, 1'b1, 16'h0102, 4'h0);
        idle(16);
        cycle(1'b0, 1'b1, 16'h0000, 4'h8);
        idle(16);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL blank[%0d]: no output captured, required %h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL blank[%0d]: got %h required %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        cycle(1'b0, 1'b1, 16'h1234, 4'hF);
        // Stop two outputs into the digit-2 dwell of the CLK_DIV=4 driver.
        while (edge_cnt < 1 || ((edge_cnt - 1) % 16) != 9) idle(1);
        cycle(1'b1, 1'b0, 16'hFFFF, 4'hF);
        idle(8);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL reset_mid[%0d]: no output captured, required %h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL reset_mid[%0d]: got %h required %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_fast();
        obs_t e, o;
        cycle(1'b0, 1'b1, 16'hFEDC, 4'h2);
        idle(9);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL fast[%0d]: no output captured, required %h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL fast[%0d]: got %h required %h", k, o, e);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        #1;
        obs_q.delete();
        test_reset();
        test_scan();
        test_load_on_tick();
        test_back_to_back();
        test_blank();
        test_reset_mid();
        test_fast();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, meaning clock cycles per digit dwell (legal range 1..2^20).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port value  input  16  four hex nibbles, digit k = value[4k+3:4k], digit 0 rightmost.
REQ-005 SHALL have port dp_in  input  4  decimal-point request per digit, bit k = digit k, active-high.
REQ-006 SHALL have port load  input  1  capture value and dp_in into shadow registers.
REQ-007 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 SHALL have port dp  output  1  decimal point, active-low, registered.
REQ-009 SHALL have port an  output  4  digit anodes, active-low, one-hot-low, registered.

Function
REQ-010 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick asserts for one cycle when count = CLK_DIV-1; CLK_DIV=1 gives a tick every cycle.
REQ-011 2-bit digit index SHALL increment on tick, wrapping 3->0; scan order 0,1,2,3,0,...
REQ-012 Shadow value/dp SHALL load on any cycle with load=1 (not in reset); displayed content uses shadow only, never live inputs.
REQ-013 Outputs SHALL be registered from the current index and shadow: output change lags index or shadow change by exactly one cycle.
REQ-014 an SHALL drive only bit[index] low; seg SHALL drive the hex code of the shadow nibble at index; dp SHALL equal ~shadow_dp[index].
REQ-015 Hex codes (seg, hex): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E; blank=7F.
REQ-016 load and tick in the same cycle SHALL both take effect; the next registered output uses the new index and the new shadow.
REQ-017 Repeated load with unchanged data SHALL cause no visible output change and no scan disturbance.
REQ-018 load SHALL NOT reset the prescaler or index.

Reset
REQ-019 While reset=1: prescaler=0, index=0, shadow value=0000, shadow dp=0000, an=1111, seg=7F, dp=1; load ignored.
REQ-020 On the first clock after reset deasserts, an SHALL become 1110 with seg showing digit 0 of the shadow, dp=1.
REQ-021 Reset asserted mid-dwell SHALL abort immediately; no partial dwell survives.

Configuration
REQ-022 With SSEG_BLANK_EN defined, digit k (k=3..1) SHALL show blank (7F) when its nibble and all higher nibbles are zero; digit 0 is never blanked; dp unaffected by blanking.
REQ-023 Without SSEG_BLANK_EN, all four digits SHALL always show their hex code; no blanking logic is synthesised.

Structure
REQ-024 A shared package sseg_pkg SHALL hold the 16-entry hex-to-segment table, the SEG_BLANK constant (7F) and the digit-count constant (4).
REQ-025 The prescaler SHALL be a sub-module scan_tick_gen (parameter CLK_DIV; ports clk, reset, tick); all other logic stays in sseg_scan_driver.

Verification (CLK_DIV=4 unless stated)
REQ-026 Reset held 3 cycles, then released -> during reset an=1111, seg=7F, dp=1; one cycle after release an=1110, seg=40.
REQ-027 load value=1234, dp_in=0000 -> over 16 cycles an cycles 1110,1101,1011,0111, seg 19,30,24,79, 4 cycles per digit, then repeats.
REQ-028 load value=ABCD, dp_in=0101, coincident with a tick -> next output already uses ABCD; dp=0 on digits 0 and 2, dp=1 on digits 1 and 3.
REQ-029 SSEG_BLANK_EN defined, value=0102 -> digit3 seg=7F, digit2=79, digit1=40, digit0=24; value=0000 -> digits 3..1 7F, digit0=40; macro undefined, value=0000 -> all digits 40.
REQ-030 Reset asserted 2 cycles into digit 2 dwell, held 1 cycle -> scan restarts at digit 0 with shadow 0000 (seg=40).
REQ-031 CLK_DIV=1, value=FEDC -> an changes every cycle; seg sequence 46,21,06,0E.
